// File: rtl/row_vector_dot_engine.sv
// Row-by-vector dot-product engine: NI lane multipliers feed an adder tree and a
// wrapping accumulator; a small FSM sequences load, pipeline drain and result hold.
module row_vector_dot_lane #(
   parameter int ELEMENT_WIDTH = 32,
   parameter bit SGN           = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [ELEMENT_WIDTH-1:0]   a,
   input  logic [ELEMENT_WIDTH-1:0]   p,
   output logic [2*ELEMENT_WIDTH-1:0] prod
);
   // With both operands extended to full product width, the low half of an
   // unsigned multiply is also the correct two's-complement product.
   logic [2*ELEMENT_WIDTH-1:0] a_ext, p_ext;
   assign a_ext = {{ELEMENT_WIDTH{SGN & a[ELEMENT_WIDTH-1]}}, a};
   assign p_ext = {{ELEMENT_WIDTH{SGN & p[ELEMENT_WIDTH-1]}}, p};

   always_ff @(posedge clk or negedge reset)
      if (!reset)  prod <= '0;
      else if (en) prod <= a_ext * p_ext;
endmodule

module row_vector_dot_engine #(
   parameter int NI            = 8,
   parameter int ELEMENT_WIDTH = 32,
   parameter int ACC_WIDTH     = 2*ELEMENT_WIDTH+16,
   parameter int SIGNED_MODE   = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start_row_by_vector,
   input  logic [31:0]                 no_of_multiples,
   input  logic [NI*ELEMENT_WIDTH-1:0] a,
   input  logic [NI*ELEMENT_WIDTH-1:0] p,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [ACC_WIDTH-1:0]        result,
   output logic                        result_valid,
   input  logic                        you_can_read,
   output logic                        give_me_only,
   output logic                        decoder_read_now,
   output logic                        busy,
   output logic                        err_zero_len
);
   localparam int PW     = 2*ELEMENT_WIDTH;
   localparam int STAGES = 2;
   localparam bit SGN    = (SIGNED_MODE != 0);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

   state_t                       state;
   logic                         accept;
   logic [STAGES:1]              vld_pipe;
   logic [NI-1:0][PW-1:0]        prod;
   logic [NI-1:0][ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0]         tree_sum, s2, acc, acc_nxt;
   logic [31:0]                  n_lat, cnt;
   logic                         drain_2nd;

   assign accept = in_valid & in_ready;

   generate
      for (genvar i = 0; i < NI; i++) begin : g_lane
         row_vector_dot_lane #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .SGN(SGN)) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (accept),
            .a     (a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
            .p     (p[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
            .prod  (prod[i])
         );
         if (ACC_WIDTH > PW) begin : g_sext
            assign prod_ext[i] = {{(ACC_WIDTH-PW){SGN & prod[i][PW-1]}}, prod[i]};
         end else if (ACC_WIDTH == PW) begin : g_same
            assign prod_ext[i] = prod[i];
         end else begin : g_trunc
            assign prod_ext[i] = prod[i][ACC_WIDTH-1:0];
         end
      end
   endgenerate

   // Heap-ordered binary tree: leaves at NI-1.., root at node 0.
   always_comb begin
      logic [ACC_WIDTH-1:0] node [2*NI-1];
      for (int j = 0; j < 2*NI-1; j++) node[j] = '0;
      for (int i = 0; i < NI; i++) node[NI-1+i] = prod_ext[i];
      for (int j = NI-2; j >= 0; j--) node[j] = node[2*j+1] + node[2*j+2];
      tree_sum = node[0];
   end

   assign acc_nxt = acc + (vld_pipe[STAGES] ? s2 : '0);

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         vld_pipe <= '0;
         s2       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};
         if (vld_pipe[1]) s2 <= tree_sum;
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state            <= IDLE;
         acc              <= '0;
         n_lat            <= '0;
         cnt              <= '0;
         drain_2nd        <= 1'b0;
         result           <= '0;
         result_valid     <= 1'b0;
         in_ready         <= 1'b0;
         give_me_only     <= 1'b0;
         decoder_read_now <= 1'b0;
         busy             <= 1'b0;
         err_zero_len     <= 1'b0;
      end else begin
         give_me_only     <= 1'b0;
         decoder_read_now <= 1'b0;
         err_zero_len     <= 1'b0;
         acc              <= acc_nxt;
         case (state)
            IDLE: if (start_row_by_vector) begin
               if (no_of_multiples != 32'd0) begin
                  n_lat    <= no_of_multiples;
                  cnt      <= '0;
                  acc      <= '0;
                  state    <= LOAD;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end else begin
                  err_zero_len <= 1'b1;
               end
            end
            LOAD: if (accept) begin
               cnt <= cnt + 32'd1;
               if (cnt == n_lat - 32'd1) begin
                  state        <= DRAIN;
                  in_ready     <= 1'b0;
                  give_me_only <= 1'b1;
                  drain_2nd    <= 1'b0;
               end
            end
            // Two drain cycles let the last chunk clear both pipeline stages.
            DRAIN: if (!drain_2nd) begin
               drain_2nd <= 1'b1;
            end else begin
               state            <= HOLD;
               result           <= acc_nxt;
               result_valid     <= 1'b1;
               decoder_read_now <= 1'b1;
            end
            HOLD: if (you_can_read) begin
               state        <= IDLE;
               result_valid <= 1'b0;
               busy         <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
